delta_gen_pipe: RTL and testbench
=================================

DELTA_GEN_PIPE -- requirements
Module: delta_gen_pipe

Interface
REQ-001 Parameter N_OUT, 4: number of output-layer channels processed per vector (>=1).
REQ-002 Parameter T_W, 8: signed target width; also activation width ACT_W.
REQ-003 Parameter Y_W, 12: signed pre-activation width (lut input width).
REQ-004 Parameter DACT_W, 16: signed activation-derivative width (dif_lut output width).
REQ-005 Parameter D_W, 16: signed delta output width.
REQ-006 Parameter FRAC_SH, 7: right-shift applied to the derivative*difference product; derivative value 1.0 = 1<<FRAC_SH.
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 in_valid  in  1  vector offered.
REQ-010 in_ready  out  1  block accepts a vector.
REQ-011 mode  in  2  0 = MSE-sigmoid, 1 = CE-sigmoid, 2 = linear, 3 = treated as 0; sampled on accept.
REQ-012 t_in  in  N_OUT*T_W  targets, channel k at bits [k*T_W +: T_W].
REQ-013 y_in  in  N_OUT*Y_W  pre-activations, channel k at bits [k*Y_W +: Y_W].
REQ-014 out_valid  out  1  delta beat valid.
REQ-015 out_ready  in  1  downstream accepts beat.
REQ-016 out_ch  out  clog2(N_OUT) (min 1)  channel index of beat.
REQ-017 out_delta  out  D_W  signed delta.
REQ-018 out_last  out  1  beat is channel N_OUT-1.
REQ-019 out_sat  out  1  saturation occurred in any stage of this beat.
REQ-020 busy  out  1  state != IDLE.

Function
REQ-021 FSM states IDLE, RUN, DRAIN; in_ready = 1 only in IDLE.
REQ-022 Accept = in_valid & in_ready: t_in, y_in, mode registered; IDLE->RUN; issue counter cleared to 0.
REQ-023 RUN: one channel issued per advancing cycle, ascending from 0; after issuing N_OUT-1 go to DRAIN.
REQ-024 DRAIN: return to IDLE in the cycle the out_last beat handshakes; in_ready high the following cycle.
REQ-025 Pipeline 3 stages: S1 activation a; S2 derivative d and difference; S3 product, shift, saturate into output register.
REQ-026 Pipeline advance enable = !out_valid | out_ready; all stages and issue counter hold when disabled.
REQ-027 First out_valid asserted 3 cycles after the accept edge with out_ready held high; one beat per cycle thereafter.
REQ-028 Mode 0/1/3: a = lut(y); mode 0/3: d = dif_lut(sign-extend a to Y_W); mode 1: d = 1<<FRAC_SH.
REQ-029 Mode 2: a = y saturated to signed T_W range, out_sat set if clipped; d = 1<<FRAC_SH.
REQ-030 diff = t - a computed in T_W+1 bits, saturated to signed T_W; out_sat set if clipped.
REQ-031 delta = (d * diff) arithmetic-shifted right by FRAC_SH, saturated to signed D_W; out_sat set if clipped.
REQ-032 While out_valid & !out_ready, out_ch, out_delta, out_last, out_sat held stable; no beat dropped or duplicated.
REQ-033 Exactly N_OUT beats per accepted vector; new vector never accepted before out_last handshake.
REQ-034 in_valid while busy is ignored; mode changes after accept have no effect on the vector in flight.

Reset
REQ-035 rst asserted: state IDLE, all pipeline valids cleared, counters 0; out_valid, out_ch, out_delta, out_last, out_sat, busy = 0; in_ready = 0 while rst high, 1 first cycle after release.
REQ-036 rst mid-vector aborts immediately; in-flight beats discarded, none emitted after release.

Verification
REQ-037 N_OUT=4, mode 2, t={10,20,-5,127}, y={4,30,100,-300}, out_ready=1 -> beats ch0..3 delta {6,-10,-105,127}, out_sat only ch3, out_last only ch3, first beat 3 cycles after accept.
REQ-038 Same vector, out_ready low 5 cycles while ch1 valid -> ch1 held stable 5 cycles, all 4 beats delivered once, in order.
REQ-039 Mode 0 and mode 1, random t/y, 1000 vectors -> every beat matches golden model built from lut/dif_lut and REQ-028..031.
REQ-040 in_valid held high with two vectors back-to-back -> second accepted cycle after first out_last handshake; in_ready low throughout first vector.
REQ-041 rst pulsed after ch1 beat of a vector -> outputs 0 immediately, no further beats, next vector processed correctly from ch0.
REQ-042 N_OUT=1 build, mode 1 -> single beat per vector with out_ch=0, out_last=1.

Source files
------------

// File: rtl/delta_gen_pipe.sv
// Output-layer delta generator: per channel, delta = act'(y) * (t - act(y)), streamed one channel per cycle
// through a 3-stage stallable pipeline. act is a hard sigmoid, act' is a*(1-a); requires 2*(T_W-1) >= FRAC_SH.
module delta_gen_pipe #(
    parameter int N_OUT   = 4,
    parameter int T_W     = 8,
    parameter int Y_W     = 12,
    parameter int DACT_W  = 16,
    parameter int D_W     = 16,
    parameter int FRAC_SH = 7,
    localparam int CH_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 mode,
    input  logic [N_OUT*T_W-1:0]       t_in,
    input  logic [N_OUT*Y_W-1:0]       y_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CH_W-1:0]            out_ch,
    output logic signed [D_W-1:0]      out_delta,
    output logic                       out_last,
    output logic                       out_sat,
    output logic                       busy
);

    localparam int YE  = (Y_W > T_W) ? Y_W : T_W;
    localparam int LW  = YE + 2;
    localparam int QW  = 2*Y_W + DACT_W + 2;
    localparam int PW  = DACT_W + T_W;
    localparam int EW  = ((PW > D_W) ? PW : D_W) + 1;
    localparam int DSH = 2*(T_W-1) - FRAC_SH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [CH_W-1:0]          LAST_CH = CH_W'(N_OUT-1);
    localparam logic signed [T_W-1:0]    T_MAX   = {1'b0, {(T_W-1){1'b1}}};
    localparam logic signed [T_W-1:0]    T_MIN   = {1'b1, {(T_W-1){1'b0}}};
    localparam logic signed [D_W-1:0]    D_MAX   = {1'b0, {(D_W-1){1'b1}}};
    localparam logic signed [D_W-1:0]    D_MIN   = {1'b1, {(D_W-1){1'b0}}};
    localparam logic signed [DACT_W-1:0] D_ONE   = DACT_W'(1 << FRAC_SH);
    localparam logic signed [LW-1:0]     L_QTR   = LW'(1 << (T_W-2));
    localparam logic signed [LW-1:0]     L_AMAX  = LW'((1 << (T_W-1)) - 1);
    localparam logic signed [QW-1:0]     Q_HALF  = QW'(1 << (T_W-1));

    logic [1:0]           state;
    logic [CH_W-1:0]      cnt;
    logic [1:0]           mode_q;
    logic [N_OUT*T_W-1:0] t_q;
    logic [N_OUT*Y_W-1:0] y_q;

    logic adv, issue;

    logic                     s1_valid, s1_last, s1_sat, s1_use_dif;
    logic [CH_W-1:0]          s1_ch;
    logic signed [T_W-1:0]    s1_a, s1_t;

    logic                     s2_valid, s2_last, s2_sat;
    logic [CH_W-1:0]          s2_ch;
    logic signed [DACT_W-1:0] s2_d;
    logic signed [T_W-1:0]    s2_diff;

    assign adv      = !out_valid || out_ready;
    assign issue    = (state == RUN) && adv;
    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= '0;
            t_q    <= '0;
            y_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_q <= mode;
                        t_q    <= t_in;
                        y_q    <= y_in;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (adv) begin
                        if (cnt == LAST_CH) begin
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + CH_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready && out_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: activation, either hard sigmoid (y/4 + half, clamped to [0, max]) or a clipped pass-through.
    logic signed [Y_W-1:0] y_sel;
    logic signed [T_W-1:0] t_sel;
    logic signed [YE-1:0]  y_ext;
    logic signed [LW-1:0]  lut_v;
    logic signed [T_W-1:0] a_nxt;
    logic                  a_clip;

    always_comb begin
        y_sel  = y_q[cnt*Y_W +: Y_W];
        t_sel  = t_q[cnt*T_W +: T_W];
        y_ext  = YE'(y_sel);
        lut_v  = (LW'(y_sel) >>> 2) + L_QTR;
        a_clip = 1'b0;
        if (mode_q == 2'd2) begin
            a_nxt = y_ext[T_W-1:0];
            if (y_ext[YE-1:T_W-1] != {(YE-T_W+1){y_ext[T_W-1]}}) begin
                a_clip = 1'b1;
                a_nxt  = y_ext[YE-1] ? T_MIN : T_MAX;
            end
        end else if (lut_v[LW-1]) begin
            a_nxt = '0;
        end else if (lut_v > L_AMAX) begin
            a_nxt = T_MAX;
        end else begin
            a_nxt = lut_v[T_W-1:0];
        end
    end

    logic signed [T_W:0]      diff_w;
    logic signed [T_W-1:0]    diff_nxt;
    logic                     diff_clip;
    logic signed [QW-1:0]     a_wide;
    logic signed [DACT_W-1:0] d_nxt;

    always_comb begin
        diff_w    = (T_W+1)'(s1_t) - (T_W+1)'(s1_a);
        diff_clip = (diff_w[T_W] != diff_w[T_W-1]);
        diff_nxt  = diff_clip ? (diff_w[T_W] ? T_MIN : T_MAX) : diff_w[T_W-1:0];
        a_wide    = QW'(s1_a);
        d_nxt     = s1_use_dif ? DACT_W'((a_wide * (Q_HALF - a_wide)) >>> DSH) : D_ONE;
    end

    logic signed [EW-1:0]  prod, shifted;
    logic signed [D_W-1:0] delta_nxt;
    logic                  delta_clip;

    always_comb begin
        prod       = EW'(s2_d) * EW'(s2_diff);
        shifted    = prod >>> FRAC_SH;
        delta_clip = (shifted[EW-1:D_W-1] != {(EW-D_W+1){shifted[D_W-1]}});
        delta_nxt  = delta_clip ? (shifted[EW-1] ? D_MIN : D_MAX) : shifted[D_W-1:0];
    end

    // Whole pipeline moves as one; last and sat are gated by valid so idle bubbles never flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_sat     <= 1'b0;
            s1_use_dif <= 1'b0;
            s1_ch      <= '0;
            s1_a       <= '0;
            s1_t       <= '0;
            s2_valid   <= 1'b0;
            s2_last    <= 1'b0;
            s2_sat     <= 1'b0;
            s2_ch      <= '0;
            s2_d       <= '0;
            s2_diff    <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_delta  <= '0;
            out_last   <= 1'b0;
            out_sat    <= 1'b0;
        end else if (adv) begin
            s1_valid   <= issue;
            s1_last    <= issue && (cnt == LAST_CH);
            s1_sat     <= a_clip;
            s1_use_dif <= (mode_q == 2'd0) || (mode_q == 2'd3);
            s1_ch      <= cnt;
            s1_a       <= a_nxt;
            s1_t       <= t_sel;
            s2_valid   <= s1_valid;
            s2_last    <= s1_last;
            s2_sat     <= s1_sat || diff_clip;
            s2_ch      <= s1_ch;
            s2_d       <= d_nxt;
            s2_diff    <= diff_nxt;
            out_valid  <= s2_valid;
            out_ch     <= s2_ch;
            out_delta  <= delta_nxt;
            out_last   <= s2_last;
            out_sat    <= s2_valid && (s2_sat || delta_clip);
        end
    end

endmodule

// File: tb/tb_delta_gen_pipe.sv
// Directed and randomized checks of delta_gen_pipe: vector table, backpressure, back-to-back, reset abort,
// and a single-channel build.
module tb_delta_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready, out_last, out_sat, busy;
    logic [1:0]  mode;
    logic [31:0] t_in;
    logic [47:0] y_in;
    logic [1:0]  out_ch;
    logic [15:0] out_delta;

    logic        n1_in_valid, n1_in_ready, n1_out_valid, n1_out_ready, n1_out_last, n1_out_sat, n1_busy;
    logic [1:0]  n1_mode;
    logic [7:0]  n1_t_in;
    logic [11:0] n1_y_in;
    logic [0:0]  n1_out_ch;
    logic [15:0] n1_out_delta;

    delta_gen_pipe #(.N_OUT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .t_in(t_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_delta(out_delta), .out_last(out_last), .out_sat(out_sat), .busy(busy)
    );

    delta_gen_pipe #(.N_OUT(1)) dut_n1 (
        .clk(clk), .rst(rst), .in_valid(n1_in_valid), .in_ready(n1_in_ready), .mode(n1_mode),
        .t_in(n1_t_in), .y_in(n1_y_in), .out_valid(n1_out_valid), .out_ready(n1_out_ready),
        .out_ch(n1_out_ch), .out_delta(n1_out_delta), .out_last(n1_out_last), .out_sat(n1_out_sat),
        .busy(n1_busy)
    );

    typedef struct {
        logic [1:0] mode;
        int         t[4];
        int         y[4];
        int         d[4];
        logic [3:0] sat;
    } vec_t;

    vec_t vecs[6];
    int total = 0;
    int bad = 0;

    task automatic compare(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference: hard sigmoid y/4+64 in [0,127], derivative a*(128-a)/128, all shifts flooring.
    task automatic model(input int m, input int t, input int y, output int d, output bit s);
        int a, der, diff, p;
        s = 1'b0;
        if (m == 2) begin
            a = clampi(y, -128, 127);
            if (a != y) s = 1'b1;
        end else begin
            a = clampi((y >>> 2) + 64, 0, 127);
        end
        der  = (m == 0 || m == 3) ? ((a * (128 - a)) >>> 7) : 128;
        diff = clampi(t - a, -128, 127);
        if (diff != t - a) s = 1'b1;
        p = (der * diff) >>> 7;
        d = clampi(p, -32768, 32767);
        if (d != p) s = 1'b1;
    endtask

    task automatic loadInputs(input vec_t v);
        mode = v.mode;
        for (int k = 0; k < 4; k++) begin
            t_in[k*8 +: 8]   = 8'(v.t[k]);
            y_in[k*12 +: 12] = 12'(v.y[k]);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit hold_valid);
        int w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) compare("accept_wait_timeout", 0, 1);
        loadInputs(v);
        in_valid = 1'b1;
        tick();
        in_valid = hold_valid;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        compare($sformatf("beat%0d_ch", idx), int'(out_ch), idx);
        compare($sformatf("beat%0d_delta", idx), int'($signed(out_delta)), v.d[idx]);
        compare($sformatf("beat%0d_last", idx), int'(out_last), int'(idx == 3));
        compare($sformatf("beat%0d_sat", idx), int'(out_sat), int'(v.sat[idx]));
    endtask

    // Collects one vector's beats; optionally stalls the sink for 5 cycles on beat stall_ch.
    task automatic collect(input vec_t v, input int stall_ch);
        int idx = 0;
        int lat = 0;
        int rdy = 0;
        bit done = 1'b0;
        logic [1:0]  sch;
        logic [15:0] sd;
        logic        sl, ss;
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            lat++;
            if (in_ready) rdy++;
            if (out_valid && idx == stall_ch) begin
                sch = out_ch; sd = out_delta; sl = out_last; ss = out_sat;
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    if (in_ready) rdy++;
                    compare("hold_stable", int'(out_valid && out_ch == sch && out_delta == sd &&
                                               out_last == sl && out_sat == ss), 1);
                end
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (idx == 0) compare("first_beat_latency", lat, 3);
                if (idx < 4) checkOutput(idx, v);
                idx++;
                if (out_last) done = 1'b1;
            end
        end
        compare("beat_count", idx, 4);
        compare("in_ready_while_busy", rdy, 0);
        tick();
        compare("idle_after_last", int'(busy), 0);
    endtask

    initial begin
        bit seen;
        int spurious;

        rst = 1'b1; in_valid = 1'b0; mode = '0; t_in = '0; y_in = '0; out_ready = 1'b1;
        n1_in_valid = 1'b0; n1_mode = '0; n1_t_in = '0; n1_y_in = '0; n1_out_ready = 1'b1;

        vecs[0].mode = 2'd2; vecs[0].t = '{10, 20, -5, 127};   vecs[0].y = '{4, 30, 100, -300};
        vecs[0].d = '{6, -10, -105, 127};    vecs[0].sat = 4'b1000;
        vecs[1].mode = 2'd1; vecs[1].t = '{0, 127, -128, 50};  vecs[1].y = '{0, 400, -400, -8};
        vecs[1].d = '{-64, 0, -128, -12};    vecs[1].sat = 4'b0000;
        vecs[2].mode = 2'd0; vecs[2].t = '{0, 100, -128, 64};  vecs[2].y = '{0, 20, -100, 200};
        vecs[2].d = '{-16, 7, -27, -5};      vecs[2].sat = 4'b0100;
        vecs[3].mode = 2'd3; vecs[3].t = '{127, -1, -128, 0};  vecs[3].y = '{-2048, 2047, 1, -3};
        vecs[3].d = '{0, 0, -32, -16};       vecs[3].sat = 4'b0100;
        vecs[4].mode = 2'd2; vecs[4].t = '{-128, 127, 0, -100}; vecs[4].y = '{-129, 127, -128, 2047};
        vecs[4].d = '{0, 0, 127, -128};      vecs[4].sat = 4'b1101;
        vecs[5].mode = 2'd1; vecs[5].t = '{5, -5, 0, 0};       vecs[5].y = '{4, -4, 3, -5};
        vecs[5].d = '{-60, -68, -64, -62};   vecs[5].sat = 4'b0000;

        tick();
        tick();
        compare("rst_in_ready", int'(in_ready), 0);
        compare("rst_out_valid", int'(out_valid), 0);
        compare("rst_busy", int'(busy), 0);
        compare("rst_out_fields", int'({out_ch, out_delta, out_last, out_sat}), 0);
        compare("rst_n1_in_ready", int'(n1_in_ready), 0);
        rst = 1'b0;
        tick();
        compare("ready_after_reset", int'(in_ready), 1);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] table vector %0d", i);
            applyStimulus(vecs[i], 1'b0);
            collect(vecs[i], -1);
        end

        $display("[TB] backpressure on ch1");
        applyStimulus(vecs[0], 1'b0);
        collect(vecs[0], 1);
        spurious = 0;
        repeat (4) begin
            tick();
            if (out_valid) spurious++;
        end
        compare("no_extra_beat", spurious, 0);

        $display("[TB] back-to-back with in_valid held");
        applyStimulus(vecs[0], 1'b1);
        loadInputs(vecs[1]);
        collect(vecs[0], -1);
        compare("b2b_ready_after_last", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        collect(vecs[1], -1);

        $display("[TB] reset after ch1 beat");
        applyStimulus(vecs[2], 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (out_valid && out_ch == 2'd1) seen = 1'b1;
        end
        compare("ch1_reached", int'(seen), 1);
        tick();
        rst = 1'b1;
        #1;
        compare("abort_out_valid", int'(out_valid), 0);
        compare("abort_busy", int'(busy), 0);
        compare("abort_in_ready", int'(in_ready), 0);
        compare("abort_out_fields", int'({out_ch, out_delta, out_last, out_sat}), 0);
        tick();
        rst = 1'b0;
        spurious = 0;
        repeat (8) begin
            tick();
            if (out_valid) spurious++;
        end
        compare("no_beats_after_abort", spurious, 0);
        applyStimulus(vecs[3], 1'b0);
        collect(vecs[3], -1);

        $display("[TB] random modes 0/1");
        for (int i = 0; i < 1000; i++) begin
            vec_t r;
            bit s;
            r.mode = 2'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                r.t[k] = int'($urandom_range(0, 255)) - 128;
                r.y[k] = int'($urandom_range(0, 4095)) - 2048;
                model(int'(r.mode), r.t[k], r.y[k], r.d[k], s);
                r.sat[k] = s;
            end
            applyStimulus(r, 1'b0);
            collect(r, -1);
        end

        $display("[TB] single-channel build");
        for (int i = 0; i < 3; i++) begin
            int tv[3] = '{50, -100, 127};
            int yv[3] = '{-8, 300, -2048};
            int ed, lat, w;
            bit es, got;
            model(1, tv[i], yv[i], ed, es);
            w = 0;
            while (!n1_in_ready && w < 20) begin
                tick();
                w++;
            end
            n1_mode = 2'd1;
            n1_t_in = 8'(tv[i]);
            n1_y_in = 12'(yv[i]);
            n1_in_valid = 1'b1;
            tick();
            n1_in_valid = 1'b0;
            lat = 0;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                tick();
                lat++;
                if (n1_out_valid) got = 1'b1;
            end
            compare("n1_latency", lat, 3);
            compare("n1_ch", int'(n1_out_ch), 0);
            compare("n1_last", int'(n1_out_last), 1);
            compare("n1_delta", int'($signed(n1_out_delta)), ed);
            compare("n1_sat", int'(n1_out_sat), int'(es));
            tick();
            compare("n1_idle_after", int'(n1_busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
